// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: sends the top min(Len, WIDTH) bits of Data MSB first, then pulses Done.
// Ports: CLK, RST (sync, active-high); Start/Data/Len request, accepted while Ready;
// Out1/Valid carry the serial bit stream; Done is a one-cycle pulse after the last bit.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LENW  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] Data,
  input  logic [LENW-1:0]  Len,
  output logic             Ready,
  output logic             Out1,
  output logic             Valid,
  output logic             Done
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [LENW-1:0] WMAX = LENW'(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [LENW-1:0]  cnt_q, cnt_d;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = IDLE;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (Start && Len != '0) begin
        state_d = SHIFT;
        shift_d = Data;
        cnt_d   = (Len > WMAX) ? WMAX : Len;
      end
      SHIFT: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - LENW'(1);
        state_d = (cnt_q == LENW'(1)) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs decode only the state and shift registers, so no input reaches them combinationally.
  assign Ready = (state_q == IDLE);
  assign Valid = (state_q == SHIFT);
  assign Done  = (state_q == DONE);
  assign Out1  = Valid & shift_q[WIDTH-1];
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: scoreboard bench for serial_pattern_tx.
module tb_serial_pattern_tx;
  localparam int W  = 8;
  localparam int LW = 4;
  typedef struct {logic b; int c;} bit_t;
  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Start = 1'b0;
  logic [W-1:0]  Data = '0;
  logic [LW-1:0] Len = '0;
  logic          Ready, Out1, Valid, Done;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  bit            mon_en = 1'b0;
  bit_t          bq[$];
  int            dq[$];
  bit_t          e;
  int            dc;
  int            n, n2;

  serial_pattern_tx #(.WIDTH(W), .LENW(LW)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Data(Data), .Len(Len),
    .Ready(Ready), .Out1(Out1), .Valid(Valid), .Done(Done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // cycle index seen at a negedge = number of rising edges so far; acceptance edge n
  // gives bit i in cycle n+i, Done in cycle n+lc and Ready again in cycle n+lc+1
  always @(negedge CLK) if (mon_en) begin
    if (Valid === 1'b1) begin
      if (bq.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = bq.pop_front();
        chk("out1_bit", {31'd0, Out1}, {31'd0, e.b});
        chk("bit_cycle", cyc, e.c);
      end
    end else chk("out1_zero_when_invalid", {31'd0, Out1}, 32'd0);
    if (Done === 1'b1) begin
      if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        dc = dq.pop_front();
        chk("done_cycle", cyc, dc);
      end
    end
  end

  // call at a negedge; acceptance happens on the next rising edge
  task automatic send(input logic [W-1:0] d, input logic [LW-1:0] l, input int keep, output int na);
    int lc;
    na = cyc + 1;
    Start = 1'b1;
    Data = d;
    Len = l;
    lc = (int'(l) > W) ? W : int'(l);
    for (int i = 0; i < lc && i < keep; i++) bq.push_back('{d[W-1-i], na + i});
    if (lc != 0 && keep >= lc) dq.push_back(na + lc);
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic ready_chk(input int lc);
    repeat (lc) @(negedge CLK);
    chk("ready_low_in_done", {31'd0, Ready}, 32'd0);
    @(negedge CLK);
    chk("ready_back", {31'd0, Ready}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("reset_ready", {31'd0, Ready}, 32'd1);
      chk("reset_valid", {31'd0, Valid}, 32'd0);
      chk("reset_done", {31'd0, Done}, 32'd0);
      @(negedge CLK);
    end
    send(8'hB2, 4'd8, 99, n);
    ready_chk(8);
    @(negedge CLK);
    send(8'hC0, 4'd3, 99, n);
    ready_chk(3);
    @(negedge CLK);
    send(8'hFF, 4'd12, 99, n);
    ready_chk(8);
    @(negedge CLK);
    Start = 1'b1;
    Data = 8'hAA;
    Len = 4'd0;
    @(negedge CLK);
    Start = 1'b0;
    repeat (3) begin
      chk("len0_ready", {31'd0, Ready}, 32'd1);
      @(negedge CLK);
    end
    send(8'hFF, 4'd8, 99, n);
    @(negedge CLK);
    Data = 8'h00;
    Len = 4'd1;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (6) @(negedge CLK);
    chk("mid_change_ready_low", {31'd0, Ready}, 32'd0);
    @(negedge CLK);
    chk("mid_change_ready_back", {31'd0, Ready}, 32'd1);
    @(negedge CLK);
    n = cyc + 1;
    Start = 1'b1;
    Data = 8'h80;
    Len = 4'd2;
    for (int k = 0; k < 3; k++) begin
      bq.push_back('{1'b1, n + 4*k});
      bq.push_back('{1'b0, n + 4*k + 1});
      dq.push_back(n + 4*k + 2);
    end
    repeat (12) @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    chk("held_start_idle", {31'd0, Ready}, 32'd1);
    send(8'hA5, 4'd8, 3, n);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_valid", {31'd0, Valid}, 32'd0);
    chk("abort_ready", {31'd0, Ready}, 32'd1);
    chk("abort_done", {31'd0, Done}, 32'd0);
    RST = 1'b0;
    send(8'h3C, 4'd4, 99, n2);
    ready_chk(4);
    repeat (3) @(negedge CLK);
    chk("bits_drained", bq.size(), 32'd0);
    chk("dones_drained", dq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
